ll_ptr_alloc_arb: RTL and testbench
===================================

# ll_ptr_alloc_arb

Arbiter and sequencer for the linked-list empty-pointer pool. It shares one `ll_empty_ptr_storage` instance between `REQ_CNT` allocating clients and a buffered free-return path. It drives the storage's read-ack and add ports so that the two never fire in the same cycle; the storage drops an add that coincides with an ack. It sits between the hash-table bucket/list engines and the pointer storage, and also reports pool occupancy.

## Interface
- `A_WIDTH`, 8: pointer width; the pool holds 2^A_WIDTH pointers.
- `REQ_CNT`, 4: number of allocating clients, 1..8.
- `FIFO_DEPTH`, 8: free-return FIFO depth, power of 2, ≥2.

- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous, active-low reset; the storage instance must be reset by the same signal, inverted.
- `alloc_req_i` in REQ_CNT: per-client allocation request, level, held until granted.
- `alloc_gnt_o` out REQ_CNT: one-hot, single-cycle grant pulse.
- `alloc_ptr_o` out A_WIDTH: allocated pointer, valid while `alloc_gnt_o` ≠ 0.
- `free_ptr_i` in A_WIDTH: pointer returned to the pool.
- `free_en_i` in 1: push `free_ptr_i`; accepted only when `free_rdy_o`=1.
- `free_rdy_o` out 1: FIFO not full.
- `free_ovf_o` out 1: sticky flag, set when `free_en_i`=1 while `free_rdy_o`=0.
- `pool_empty_o` out 1: equals `st_val_i` inverted.
- `in_use_cnt_o` out A_WIDTH+1: number of pointers currently allocated.
- `st_rd_ack_o` out 1: storage `next_empty_ptr_rd_ack_i`.
- `st_ptr_i` in A_WIDTH: storage `next_empty_ptr_o`.
- `st_val_i` in 1: storage `next_empty_ptr_val_o`.
- `st_add_ptr_o` out A_WIDTH: storage `add_empty_ptr_i`.
- `st_add_en_o` out 1: storage `add_empty_ptr_en_i`.

## Operation
- **Reset values:** `alloc_gnt_o`=0, `alloc_ptr_o`=0, `free_ovf_o`=0, `in_use_cnt_o`=0, FIFO empty (`free_rdy_o`=1), RR pointer=0, `last_srv`=FREE. Storage comes out of reset all-empty, so `pool_empty_o`=0.
- **Masked requests:** `req_m` = `alloc_req_i` & ~`alloc_gnt_o`. A client whose grant is being shown this cycle is excluded, so a late-dropped request is never granted twice.
- **Eligibility:**
  - ALLOC eligible = |`req_m` && `st_val_i`.
  - FREE eligible = FIFO not empty.
- **Slot decision:** combinational, one per cycle; states NONE / ALLOC / FREE.
  - Only one eligible: serve it.
  - Both eligible: serve the opposite of `last_srv`, a 1-bit register updated on every served slot.
- **ALLOC slot:**
  - `st_rd_ack_o`=1.
  - The winner is the first set bit of `req_m` at or after the RR pointer, with wrap-around.
  - Next edge: `alloc_gnt_o` = one-hot winner, `alloc_ptr_o` = `st_ptr_i`, RR pointer = (winner+1) mod REQ_CNT, `in_use_cnt_o` +1.
- **FREE slot:**
  - `st_add_en_o`=1, `st_add_ptr_o` = FIFO head.
  - Next edge: pop the FIFO, `in_use_cnt_o` −1.
- **Mutual exclusion:** `st_rd_ack_o` and `st_add_en_o` are never both 1.
- **FIFO:**
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Push when full is dropped and sets `free_ovf_o`.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap; an extra occupancy bit distinguishes full from empty.
- **Pool empty:** requests wait with no grant and no timeout. Pending FREE slots refill the pool, and a pointer added at edge t is grantable from cycle t.
- **Not checked:** double free and freeing an unallocated pointer. `in_use_cnt_o` saturates at 0 and at 2^A_WIDTH and never wraps.
- **Reset mid-operation:** all state returns to reset values immediately. An in-flight grant is lost, and clients must re-request.

## Timing
- Request sampled in cycle t → grant and pointer valid in cycle t+1, for one cycle only.
- `st_rd_ack_o` and `st_add_en_o` are combinational from registered state plus `alloc_req_i`/`st_val_i`. The storage mask updates at the edge ending the slot, so `st_ptr_i` is fresh every cycle.
- Back-to-back ALLOC slots are allowed every cycle when the FIFO is empty.
- Free latency: push at edge t → earliest storage add in cycle t+1.
- Sustained throughput with both sides busy: one grant every 2 cycles and one drain every 2 cycles.
- `free_rdy_o` reflects registered occupancy and is not bypassed by a same-cycle pop.

## Test plan
- **RR fairness:** after reset, clients 0..3 request continuously and each drops its request at its grant → grants in order 0,1,2,3 on cycles 1..4, pointers 0,1,2,3, `in_use_cnt_o`=4.
- **Exhaustion:** A_WIDTH=2, one client allocates 4 pointers, then requests again → no grant and `pool_empty_o`=1. Then free pointer 2 → grant of pointer 2 two cycles after the push; `in_use_cnt_o` goes 4→3→4.
- **Contention:** FIFO holds {5,6}, clients 0 and 1 request → slot order ALLOC, FREE, ALLOC, FREE. `st_rd_ack_o`&`st_add_en_o` is 0 on every cycle (assertion).
- **FIFO full:** with FIFO_DEPTH=8 and allocations blocked, push 9 frees → `free_rdy_o`=0 after the 8th, the 9th is dropped, and `free_ovf_o`=1 (sticky) until reset.
- **Push+pop same cycle:** FIFO occupancy 3, push while draining → occupancy stays 3, and the drained order matches push order.
- **Reset mid-grant:** assert `rst_n_i`=0 in the cycle a grant is shown → `alloc_gnt_o`=0 at once. After release, the storage serves pointer 0 again and `in_use_cnt_o`=0.

Source files
------------

// File: rtl/ll_ptr_alloc_arb.sv
// Shares one empty-pointer storage between REQ_CNT round-robin allocators and a
// buffered free-return FIFO; at most one storage access (ack or add) per cycle.
module ll_ptr_alloc_arb #(
   parameter int unsigned A_WIDTH    = 8,
   parameter int unsigned REQ_CNT    = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [REQ_CNT-1:0] alloc_req_i,
   output logic [REQ_CNT-1:0] alloc_gnt_o,
   output logic [A_WIDTH-1:0] alloc_ptr_o,
   input  logic [A_WIDTH-1:0] free_ptr_i,
   input  logic               free_en_i,
   output logic               free_rdy_o,
   output logic               free_ovf_o,
   output logic               pool_empty_o,
   output logic [A_WIDTH:0]   in_use_cnt_o,
   output logic               st_rd_ack_o,
   input  logic [A_WIDTH-1:0] st_ptr_i,
   input  logic               st_val_i,
   output logic [A_WIDTH-1:0] st_add_ptr_o,
   output logic               st_add_en_o
);

   localparam int unsigned RW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam logic [FW:0]      OCC_FULL = (FW+1)'(FIFO_DEPTH);
   localparam logic [A_WIDTH:0] CNT_MAX  = {1'b1, {A_WIDTH{1'b0}}};

   typedef enum logic [1:0] {SLOT_NONE, SLOT_ALLOC, SLOT_FREE} slot_e;
   typedef enum logic {SRV_FREE, SRV_ALLOC} srv_e;

   slot_e               slot;
   srv_e                last_srv_q, last_srv_d;
   logic [REQ_CNT-1:0]  gnt_q, gnt_d;
   logic [REQ_CNT-1:0]  req_m, req_rot;
   logic [A_WIDTH-1:0]  ptr_q, ptr_d;
   logic                ovf_q, ovf_d;
   logic [A_WIDTH:0]    cnt_q, cnt_d;
   logic [RW-1:0]       rr_q, rr_d, win_idx;
   logic [FW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [FW:0]         occ_q, occ_d;
   logic [A_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [A_WIDTH-1:0]  mem_d [FIFO_DEPTH];
   logic                alloc_elig, free_elig, fifo_full, push, pop, win_found;
   int unsigned         win_off, win_sum;

   // A grant being shown this cycle masks its client so a late drop is not re-served.
   assign req_m      = alloc_req_i & ~gnt_q;
   assign fifo_full  = (occ_q == OCC_FULL);
   assign alloc_elig = (|req_m) & st_val_i;
   assign free_elig  = (occ_q != '0);

   // Rotate so bit 0 is the RR pointer; the first set bit is the winner offset.
   always_comb begin
      req_rot   = REQ_CNT'({req_m, req_m} >> rr_q);
      win_found = 1'b0;
      win_off   = 0;
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            win_off   = i;
         end
      end
      win_sum = 32'(rr_q) + win_off;
      if (win_sum >= REQ_CNT) win_sum = win_sum - REQ_CNT;
      win_idx = RW'(win_sum);
   end

   always_comb begin
      slot       = SLOT_NONE;
      last_srv_d = last_srv_q;
      if (alloc_elig && free_elig)
         slot = (last_srv_q == SRV_ALLOC) ? SLOT_FREE : SLOT_ALLOC;
      else if (alloc_elig)
         slot = SLOT_ALLOC;
      else if (free_elig)
         slot = SLOT_FREE;
      if (slot == SLOT_ALLOC)     last_srv_d = SRV_ALLOC;
      else if (slot == SLOT_FREE) last_srv_d = SRV_FREE;
   end

   always_comb begin
      st_rd_ack_o  = (slot == SLOT_ALLOC);
      st_add_en_o  = (slot == SLOT_FREE);
      st_add_ptr_o = mem_q[rd_q];
   end

   always_comb begin
      push   = free_en_i & ~fifo_full;
      pop    = (slot == SLOT_FREE);
      gnt_d  = '0;
      ptr_d  = ptr_q;
      rr_d   = rr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q | (free_en_i & fifo_full);
      wr_d   = wr_q;
      rd_d   = rd_q;
      mem_d  = mem_q;
      if (slot == SLOT_ALLOC) begin
         gnt_d = REQ_CNT'(1) << win_idx;
         ptr_d = st_ptr_i;
         rr_d  = (win_sum + 1 >= REQ_CNT) ? '0 : RW'(win_sum + 1);
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      if (push) begin
         mem_d[wr_q] = free_ptr_i;
         wr_d        = wr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_srv_q <= SRV_FREE;
         gnt_q      <= '0;
         ptr_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         rr_q       <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         occ_q      <= '0;
         mem_q      <= '{default: '0};
      end else begin
         last_srv_q <= last_srv_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         rr_q       <= rr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         occ_q      <= occ_d;
         mem_q      <= mem_d;
      end
   end

   assign alloc_gnt_o  = gnt_q;
   assign alloc_ptr_o  = ptr_q;
   assign free_ovf_o   = ovf_q;
   assign in_use_cnt_o = cnt_q;
   assign free_rdy_o   = ~fifo_full;
   assign pool_empty_o = ~st_val_i;

endmodule

// File: tb/tb_ll_ptr_alloc_arb.sv
// Bench for ll_ptr_alloc_arb: behavioural pointer-storage model plus a queue-based
// reference of the arbitration rules, directed scenarios then random traffic.
module tb_ll_ptr_alloc_arb;

   localparam int AW = 2;
   localparam int RC = 4;
   localparam int FD = 8;
   localparam int NP = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic [RC-1:0] alloc_req;
   logic [RC-1:0] alloc_gnt_o;
   logic [AW-1:0] alloc_ptr_o;
   logic [AW-1:0] free_ptr;
   logic          free_en;
   logic          free_rdy_o;
   logic          free_ovf_o;
   logic          pool_empty_o;
   logic [AW:0]   in_use_cnt_o;
   logic          st_rd_ack_o;
   logic [AW-1:0] st_ptr;
   logic          st_val;
   logic [AW-1:0] st_add_ptr_o;
   logic          st_add_en_o;

   ll_ptr_alloc_arb #(.A_WIDTH(AW), .REQ_CNT(RC), .FIFO_DEPTH(FD)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .alloc_req_i  (alloc_req),
      .alloc_gnt_o  (alloc_gnt_o),
      .alloc_ptr_o  (alloc_ptr_o),
      .free_ptr_i   (free_ptr),
      .free_en_i    (free_en),
      .free_rdy_o   (free_rdy_o),
      .free_ovf_o   (free_ovf_o),
      .pool_empty_o (pool_empty_o),
      .in_use_cnt_o (in_use_cnt_o),
      .st_rd_ack_o  (st_rd_ack_o),
      .st_ptr_i     (st_ptr),
      .st_val_i     (st_val),
      .st_add_ptr_o (st_add_ptr_o),
      .st_add_en_o  (st_add_en_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Storage: lowest free pointer offered; an add coinciding with an ack is dropped.
   logic pool_free [NP];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NP; i++) pool_free[i] <= 1'b1;
      end else if (st_rd_ack_o) begin
         pool_free[st_ptr] <= 1'b0;
      end else if (st_add_en_o) begin
         pool_free[st_add_ptr_o] <= 1'b1;
      end
   end

   always_comb begin
      st_val = 1'b0;
      st_ptr = '0;
      for (int i = NP - 1; i >= 0; i--) begin
         if (pool_free[i]) begin
            st_val = 1'b1;
            st_ptr = AW'(i);
         end
      end
   end

   int            total = 0;
   int            bad   = 0;
   int            m_gnt;
   logic [AW-1:0] m_ptr;
   int            m_cnt;
   bit            m_ovf;
   int            m_rr;
   int            m_last;
   logic [AW-1:0] m_fifo [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RC-1:0] gvec();
      logic [RC-1:0] v;
      v = '0;
      if (m_gnt >= 0) v[m_gnt] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_gnt  = -1;
      m_ptr  = '0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_rr   = 0;
      m_last = 0;
      m_fifo.delete();
   endtask

   // One clock: drive inputs, check the slot decision, advance the model, check registers.
   task automatic step(input logic [RC-1:0] req, input bit fen, input logic [AW-1:0] fptr,
                       output int slot_obs);
      int            slot;
      int            win;
      bit            found;
      bit            full;
      logic [RC-1:0] rm;
      bit            ae, fe;
      alloc_req = req;
      free_en   = fen;
      free_ptr  = fptr;
      #1;
      rm = req & ~gvec();
      ae = (rm != '0) && st_val;
      fe = m_fifo.size() > 0;
      if (ae && fe) slot = (m_last == 1) ? 2 : 1;
      else if (ae)  slot = 1;
      else if (fe)  slot = 2;
      else          slot = 0;
      slot_obs = st_rd_ack_o ? 1 : (st_add_en_o ? 2 : 0);
      chk("mutex", 32'(st_rd_ack_o & st_add_en_o), 0);
      chk("rd_ack", 32'(st_rd_ack_o), 32'(slot == 1));
      chk("add_en", 32'(st_add_en_o), 32'(slot == 2));
      if (slot == 2) chk("add_ptr", 32'(st_add_ptr_o), 32'(m_fifo[0]));
      chk("free_rdy", 32'(free_rdy_o), 32'(m_fifo.size() < FD));
      chk("pool_empty", 32'(pool_empty_o), 32'(!st_val));

      full  = m_fifo.size() >= FD;
      m_gnt = -1;
      if (slot == 1) begin
         found = 1'b0;
         win   = 0;
         for (int k = 0; k < RC; k++) begin
            if (!found && rm[(m_rr + k) % RC]) begin
               found = 1'b1;
               win   = (m_rr + k) % RC;
            end
         end
         m_gnt  = win;
         m_ptr  = st_ptr;
         m_rr   = (win + 1) % RC;
         if (m_cnt < NP) m_cnt++;
         m_last = 1;
      end
      if (slot == 2) begin
         void'(m_fifo.pop_front());
         if (m_cnt > 0) m_cnt--;
         m_last = 0;
      end
      if (fen) begin
         if (full) m_ovf = 1'b1;
         else      m_fifo.push_back(fptr);
      end

      @(posedge clk);
      #1;
      chk("gnt", 32'(alloc_gnt_o), 32'(gvec()));
      if (m_gnt >= 0) chk("ptr", 32'(alloc_ptr_o), 32'(m_ptr));
      chk("cnt", 32'(in_use_cnt_o), 32'(m_cnt));
      chk("ovf", 32'(free_ovf_o), 32'(m_ovf));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RC-1:0] rq;
      int            s;
      int            guard;
      int            v;

      rst_n     = 1'b0;
      alloc_req = '0;
      free_en   = 1'b0;
      free_ptr  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(alloc_gnt_o), 0);
      chk("rst_ptr", 32'(alloc_ptr_o), 0);
      chk("rst_ovf", 32'(free_ovf_o), 0);
      chk("rst_cnt", 32'(in_use_cnt_o), 0);
      chk("rst_rdy", 32'(free_rdy_o), 1);
      chk("rst_pool_empty", 32'(pool_empty_o), 0);
      chk("rst_ack", 32'(st_rd_ack_o), 0);
      chk("rst_add", 32'(st_add_en_o), 0);
      rst_n = 1'b1;

      // Round-robin fairness, each client drops at its grant.
      rq = 4'hF;
      for (int i = 0; i < RC; i++) begin
         step(rq, 1'b0, '0, s);
         chk("rr_gnt", 32'(alloc_gnt_o), 32'(1) << i);
         chk("rr_ptr", 32'(alloc_ptr_o), 32'(i));
         rq[i] = 1'b0;
      end
      chk("rr_cnt", 32'(in_use_cnt_o), 4);

      // Exhaustion and refill.
      repeat (3) step(4'b0001, 1'b0, '0, s);
      chk("exh_empty", 32'(pool_empty_o), 1);
      chk("exh_nognt", 32'(alloc_gnt_o), 0);
      step(4'b0001, 1'b1, 2'd2, s);
      chk("exh_cnt4", 32'(in_use_cnt_o), 4);
      step(4'b0001, 1'b0, '0, s);
      chk("exh_cnt3", 32'(in_use_cnt_o), 3);
      chk("exh_nognt2", 32'(alloc_gnt_o), 0);
      step(4'b0001, 1'b0, '0, s);
      chk("exh_gnt", 32'(alloc_gnt_o), 1);
      chk("exh_ptr", 32'(alloc_ptr_o), 2);
      chk("exh_cnt4b", 32'(in_use_cnt_o), 4);

      // Contention alternates ALLOC and FREE.
      step(4'b0000, 1'b1, 2'd0, s);
      step(4'b0000, 1'b1, 2'd1, s);
      step(4'b0000, 1'b0, '0, s);
      step(4'b0011, 1'b1, 2'd2, s);
      chk("cont_slot0", 32'(s), 1);
      step(4'b0010, 1'b1, 2'd3, s);
      chk("cont_slot1", 32'(s), 2);
      step(4'b0010, 1'b0, '0, s);
      chk("cont_slot2", 32'(s), 1);
      step(4'b0000, 1'b0, '0, s);
      chk("cont_slot3", 32'(s), 2);

      // Fill the FIFO under contention, then overflow it.
      guard = 0;
      v     = 0;
      rq    = 4'hF;
      while (free_rdy_o && guard < 200) begin
         step(rq & ~gvec(), 1'b1, AW'(v), s);
         v++;
         guard++;
      end
      chk("fill_done", 32'(free_rdy_o), 0);
      step(4'b0000, 1'b1, 2'd3, s);
      chk("ovf_set", 32'(free_ovf_o), 1);

      // Drain to occupancy 3, then push while popping.
      guard = 0;
      while (m_fifo.size() > 3 && guard < 20) begin
         step(4'b0000, 1'b0, '0, s);
         guard++;
      end
      chk("pp_start_rdy", 32'(free_rdy_o), 1);
      step(4'b0000, 1'b1, 2'd1, s);
      step(4'b0000, 1'b1, 2'd3, s);
      step(4'b0000, 1'b1, 2'd0, s);
      step(4'b0000, 1'b1, 2'd2, s);
      chk("pp_head0", 32'(st_add_ptr_o), 3);
      step(4'b0000, 1'b0, '0, s);
      chk("pp_head1", 32'(st_add_ptr_o), 0);
      step(4'b0000, 1'b0, '0, s);
      chk("pp_head2", 32'(st_add_ptr_o), 2);
      repeat (3) step(4'b0000, 1'b0, '0, s);
      chk("ovf_sticky", 32'(free_ovf_o), 1);

      // Random traffic with held requests.
      rq = '0;
      for (int n = 0; n < 1500; n++) begin
         rq = rq & ~gvec();
         for (int c = 0; c < RC; c++)
            if (!rq[c] && $urandom_range(0, 2) == 0) rq[c] = 1'b1;
         step(rq, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NP - 1)), s);
      end

      // Reset while a grant is shown.
      guard = 0;
      rq    = 4'hF;
      while (alloc_gnt_o == '0 && guard < 50) begin
         step(rq & ~gvec(), 1'b0, '0, s);
         guard++;
      end
      chk("pre_rst_gnt_seen", 32'(alloc_gnt_o != '0), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(alloc_gnt_o), 0);
      chk("mid_rst_cnt", 32'(in_use_cnt_o), 0);
      chk("mid_rst_ovf", 32'(free_ovf_o), 0);
      chk("mid_rst_rdy", 32'(free_rdy_o), 1);
      model_reset();
      alloc_req = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b0100, 1'b0, '0, s);
      chk("post_rst_gnt", 32'(alloc_gnt_o), 4);
      chk("post_rst_ptr", 32'(alloc_ptr_o), 0);
      chk("post_rst_cnt", 32'(in_use_cnt_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
